// File: rtl/xbar_periph_1n.sv
// TL-UL 1:N peripheral crossbar: table-driven decode, in-order tracking, internal error responder.
// Optional XBAR_PERIPH_RSP_REG_EN puts a 2-entry skid register on the host D channel.
package xbar_periph_1n_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  // Devices 0..9 own 4 KiB windows; device 10 spans the whole 64 KiB block underneath them.
  localparam logic [10:0][31:0] DefaultBase = {
    32'h4000_0000, 32'h4000_9000, 32'h4000_8000, 32'h4000_7000, 32'h4000_6000, 32'h4000_5000,
    32'h4000_4000, 32'h4000_3000, 32'h4000_2000, 32'h4000_1000, 32'h4000_0000
  };
  localparam logic [10:0][31:0] DefaultMask = {32'h0000_FFFF, {10{32'h0000_0FFF}}};

endpackage

module xbar_periph_1n
  import xbar_periph_1n_pkg::*;
#(
  parameter int unsigned        N         = 11,
  parameter int unsigned        MaxOutstd = 4,
  parameter int unsigned        ErrCntW   = 8,
  parameter logic [N-1:0][31:0] AddrBase  = DefaultBase,
  parameter logic [N-1:0][31:0] AddrMask  = DefaultMask
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  tl_h2d_t              tl_h_i,
  output tl_d2h_t              tl_h_o,
  output tl_h2d_t [N-1:0]      tl_d_o,
  input  tl_d2h_t [N-1:0]      tl_d_i,
  output logic    [3:0]        outstd_o,
  output logic    [ErrCntW-1:0] err_cnt_o
);

  localparam int unsigned     DevW   = $clog2(N + 1);
  localparam logic [DevW-1:0] ErrIdx = DevW'(N);

  typedef enum logic [0:0] {ErrIdle, ErrResp} err_st_e;

  logic               init_q, init_d;
  logic [3:0]         outstd_q, outstd_d;
  logic [DevW-1:0]    cur_dev_q, cur_dev_d;
  err_st_e            err_st_q, err_st_d;
  logic [7:0]         err_src_q, err_src_d;
  logic [1:0]         err_size_q, err_size_d;
  logic               err_get_q, err_get_d;
  logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;

  logic [DevW-1:0] sel;
  logic            stall, sel_ready, a_ready, a_hs, d_hs, rsp_ready;
  tl_d2h_t         rsp;

  // Reverse scan so the lowest hitting index wins on overlapping windows.
  always_comb begin
    sel = ErrIdx;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if ((tl_h_i.a_address & ~AddrMask[i]) == AddrBase[i]) sel = DevW'(i);
    end
  end

  assign stall = (outstd_q == 4'(MaxOutstd)) || ((outstd_q != 4'd0) && (sel != cur_dev_q));

  always_comb begin
    sel_ready = (err_st_q == ErrIdle);
    for (int i = 0; i < int'(N); i++) begin
      if (sel == DevW'(i)) sel_ready = tl_d_i[i].a_ready;
    end
  end

  assign a_ready = init_q & ~stall & sel_ready;
  assign a_hs    = tl_h_i.a_valid & a_ready;

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      tl_d_o[i]         = tl_h_i;
      tl_d_o[i].a_valid = init_q & tl_h_i.a_valid & (sel == DevW'(i)) & ~stall;
      tl_d_o[i].d_ready = rsp_ready & (cur_dev_q == DevW'(i));
    end
  end

  // Response source: the device that owns the in-flight requests, or the error responder.
  always_comb begin
    rsp          = '0;
    rsp.d_valid  = (err_st_q == ErrResp);
    rsp.d_opcode = err_get_q ? AccessAckData : AccessAck;
    rsp.d_size   = err_size_q;
    rsp.d_source = err_src_q;
    rsp.d_data   = 32'hFFFF_FFFF;
    rsp.d_error  = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      if (cur_dev_q == DevW'(i)) rsp = tl_d_i[i];
    end
    rsp.d_valid = rsp.d_valid & init_q;
    rsp.a_ready = 1'b0;
  end

`ifdef XBAR_PERIPH_RSP_REG_EN
  tl_d2h_t [1:0] skid_q, skid_d;
  logic [1:0]    skid_cnt_q, skid_cnt_d;
  logic          push, pop;

  assign rsp_ready = init_q & (skid_cnt_q != 2'd2);
  assign push      = rsp.d_valid & rsp_ready;
  assign pop       = (skid_cnt_q != 2'd0) & tl_h_i.d_ready;
  assign d_hs      = pop;

  always_comb begin
    skid_d     = skid_q;
    skid_cnt_d = skid_cnt_q;
    if (pop) begin
      skid_d[0]  = skid_q[1];
      skid_cnt_d = skid_cnt_d - 2'd1;
    end
    if (push) begin
      skid_d[skid_cnt_d[0]] = rsp;
      skid_cnt_d            = skid_cnt_d + 2'd1;
    end
    tl_h_o         = skid_q[0];
    tl_h_o.d_valid = (skid_cnt_q != 2'd0);
    tl_h_o.a_ready = a_ready;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_q     <= '0;
      skid_cnt_q <= 2'd0;
    end else begin
      skid_q     <= skid_d;
      skid_cnt_q <= skid_cnt_d;
    end
  end
`else
  assign rsp_ready = init_q & tl_h_i.d_ready;
  assign d_hs      = rsp.d_valid & tl_h_i.d_ready;

  always_comb begin
    tl_h_o         = rsp;
    tl_h_o.a_ready = a_ready;
  end
`endif

  always_comb begin
    err_st_d   = err_st_q;
    err_src_d  = err_src_q;
    err_size_d = err_size_q;
    err_get_d  = err_get_q;
    err_cnt_d  = err_cnt_q;
    unique case (err_st_q)
      ErrIdle: begin
        if (a_hs && (sel == ErrIdx)) begin
          err_st_d   = ErrResp;
          err_src_d  = tl_h_i.a_source;
          err_size_d = tl_h_i.a_size;
          err_get_d  = (tl_h_i.a_opcode == Get);
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ErrCntW'(1);
        end
      end
      ErrResp: begin
        if (rsp_ready && (cur_dev_q == ErrIdx)) err_st_d = ErrIdle;
      end
      default: err_st_d = ErrIdle;
    endcase
  end

  always_comb begin
    init_d    = 1'b1;
    cur_dev_d = a_hs ? sel : cur_dev_q;
    case ({a_hs, d_hs})
      2'b10:   outstd_d = outstd_q + 4'd1;
      2'b01:   outstd_d = outstd_q - 4'd1;
      default: outstd_d = outstd_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q     <= 1'b0;
      outstd_q   <= 4'd0;
      cur_dev_q  <= '0;
      err_st_q   <= ErrIdle;
      err_src_q  <= 8'd0;
      err_size_q <= 2'd0;
      err_get_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      init_q     <= init_d;
      outstd_q   <= outstd_d;
      cur_dev_q  <= cur_dev_d;
      err_st_q   <= err_st_d;
      err_src_q  <= err_src_d;
      err_size_q <= err_size_d;
      err_get_q  <= err_get_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign outstd_o  = outstd_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_xbar_periph_1n.sv
// Bench for xbar_periph_1n (default build): directed scenarios plus random traffic checked against
// a queue of in-order expected responses.
module tb_xbar_periph_1n;
  import xbar_periph_1n_pkg::*;

  localparam int NDEV = 11;
  localparam int MAXO = 4;

  typedef struct {
    int         dev;
    logic [7:0] src;
    logic [1:0] size;
    logic       get;
  } pend_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  tl_h2d_t            h_i;
  tl_d2h_t            h_o;
  tl_h2d_t [NDEV-1:0] d_o;
  tl_d2h_t [NDEV-1:0] d_i;
  logic [3:0]         outstd;
  logic [7:0]         err_cnt;

  pend_t       pend[$];
  int          cur, m_errcnt, checks, errors;
  logic        dev_rdy[NDEV];
  logic        dev_rsp_en[NDEV];
  logic [31:0] dev_data[NDEV];
  bit          s_a_hs, s_d_hs;
  int          s_sel;

  xbar_periph_1n #(.N(NDEV), .MaxOutstd(MAXO), .ErrCntW(8)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .tl_h_i   (h_i),
    .tl_h_o   (h_o),
    .tl_d_o   (d_o),
    .tl_d_i   (d_i),
    .outstd_o (outstd),
    .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic int exp_sel(input logic [31:0] a);
    for (int i = 0; i < 10; i++) if (a[31:12] == 20'h40000 + 20'(i)) return i;
    if (a[31:16] == 16'h4000) return 10;
    return NDEV;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_dev();
    for (int i = 0; i < NDEV; i++) begin
      d_i[i]         = '0;
      d_i[i].a_ready = dev_rdy[i];
      if (pend.size() > 0 && pend[0].dev == i) begin
        d_i[i].d_valid  = dev_rsp_en[i];
        d_i[i].d_opcode = pend[0].get ? AccessAckData : AccessAck;
        d_i[i].d_size   = pend[0].size;
        d_i[i].d_source = pend[0].src;
        d_i[i].d_data   = dev_data[i];
      end
    end
  endtask

  task automatic req(input logic v, input logic [31:0] addr, input logic [2:0] op,
                     input logic [7:0] src);
    h_i.a_valid   = v;
    h_i.a_address = addr;
    h_i.a_opcode  = op;
    h_i.a_source  = src;
    h_i.a_size    = 2'd2;
    h_i.a_mask    = 4'hF;
    h_i.a_data    = $urandom;
  endtask

  task automatic sample();
    bit stall, err_busy, ardy, edv;
    drive_dev();
    #1;
    s_sel    = exp_sel(h_i.a_address);
    err_busy = 0;
    foreach (pend[k]) if (pend[k].dev == NDEV) err_busy = 1;
    stall = (pend.size() == MAXO) || (pend.size() != 0 && s_sel != cur);
    ardy  = !stall && ((s_sel == NDEV) ? !err_busy : dev_rdy[s_sel]);
    chk("a_ready", 32'(h_o.a_ready), 32'(ardy));
    for (int i = 0; i < NDEV; i++) begin
      chk($sformatf("a_valid[%0d]", i), 32'(d_o[i].a_valid),
          32'(h_i.a_valid && s_sel == i && !stall));
      chk($sformatf("d_ready[%0d]", i), 32'(d_o[i].d_ready), 32'(h_i.d_ready && cur == i));
    end
    edv = pend.size() > 0 && (pend[0].dev == NDEV || dev_rsp_en[pend[0].dev]);
    chk("d_valid", 32'(h_o.d_valid), 32'(edv));
    if (edv) begin
      chk("d_source", 32'(h_o.d_source), 32'(pend[0].src));
      chk("d_size", 32'(h_o.d_size), 32'(pend[0].size));
      chk("d_opcode", 32'(h_o.d_opcode), 32'(pend[0].get ? AccessAckData : AccessAck));
      chk("d_error", 32'(h_o.d_error), 32'(pend[0].dev == NDEV));
      chk("d_data", h_o.d_data, (pend[0].dev == NDEV) ? 32'hFFFF_FFFF : dev_data[pend[0].dev]);
    end
    chk("outstd", 32'(outstd), 32'(pend.size()));
    chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
    s_a_hs = h_i.a_valid && ardy;
    s_d_hs = edv && h_i.d_ready;
  endtask

  task automatic advance();
    @(posedge clk);
    if (s_d_hs) void'(pend.pop_front());
    if (s_a_hs) begin
      pend.push_back('{dev: s_sel, src: h_i.a_source, size: h_i.a_size,
                       get: (h_i.a_opcode == Get)});
      cur = s_sel;
      if (s_sel == NDEV && m_errcnt < 255) m_errcnt++;
    end
    #2;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic drain();
    h_i.a_valid = 1'b0;
    h_i.d_ready = 1'b1;
    for (int i = 0; i < NDEV; i++) dev_rsp_en[i] = 1'b1;
    for (int n = 0; n < 40 && pend.size() != 0; n++) cycle();
    chk("drain_outstd", 32'(outstd), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; cur = 0; m_errcnt = 0;
    h_i = '0;
    for (int i = 0; i < NDEV; i++) begin
      dev_rdy[i] = 1'b1; dev_rsp_en[i] = 1'b0; dev_data[i] = $urandom;
    end
    drive_dev();
    // Reset: outputs must stay quiet even with host and device activity present.
    h_i.a_valid = 1'b1; h_i.a_address = 32'h4000_2000; h_i.d_ready = 1'b1;
    d_i[0].d_valid = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_a_ready", 32'(h_o.a_ready), 32'd0);
    chk("rst_d_valid", 32'(h_o.d_valid), 32'd0);
    chk("rst_outstd", 32'(outstd), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    for (int i = 0; i < NDEV; i++) begin
      chk($sformatf("rst_a_valid[%0d]", i), 32'(d_o[i].a_valid), 32'd0);
      chk($sformatf("rst_d_ready[%0d]", i), 32'(d_o[i].d_ready), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    h_i.a_valid = 1'b0;
    @(posedge clk);
    #2;

    // Get to dev3, pass-through response data.
    dev_data[3] = 32'h1234_5678;
    req(1'b1, 32'h4000_3004, Get, 8'd1);
    cycle();
    h_i.a_valid = 1'b0; dev_rsp_en[3] = 1'b1;
    sample();
    chk("t1_data", h_o.d_data, 32'h1234_5678);
    chk("t1_error", 32'(h_o.d_error), 32'd0);
    advance();

    // Put to unmapped address answered by the error responder one cycle later.
    h_i.d_ready = 1'b0;
    req(1'b1, 32'hDEAD_0000, PutFullData, 8'd5);
    cycle();
    h_i.a_valid = 1'b0;
    sample();
    chk("t2_d_valid", 32'(h_o.d_valid), 32'd1);
    chk("t2_d_error", 32'(h_o.d_error), 32'd1);
    chk("t2_d_opcode", 32'(h_o.d_opcode), 32'(AccessAck));
    chk("t2_d_source", 32'(h_o.d_source), 32'd5);
    chk("t2_err_cnt", 32'(err_cnt), 32'd1);
    advance();
    h_i.d_ready = 1'b1;
    cycle();

    // Outstanding limit.
    dev_rsp_en[1] = 1'b0;
    for (int k = 0; k < MAXO; k++) begin
      req(1'b1, 32'h4000_1000 + 32'(k * 4), Get, 8'(16 + k));
      cycle();
    end
    req(1'b1, 32'h4000_1010, Get, 8'd20);
    sample();
    chk("t3_full_a_ready", 32'(h_o.a_ready), 32'd0);
    chk("t3_full_outstd", 32'(outstd), 32'd4);
    advance();
    dev_rsp_en[1] = 1'b1;
    cycle();
    dev_rsp_en[1] = 1'b0;
    sample();
    chk("t3_resume_a_ready", 32'(h_o.a_ready), 32'd1);
    advance();
    drain();

    // Device switch blocked while a response is pending.
    dev_rsp_en[1] = 1'b0;
    req(1'b1, 32'h4000_1020, Get, 8'd30);
    cycle();
    req(1'b1, 32'h4000_2000, Get, 8'd31);
    for (int k = 0; k < 2; k++) begin
      sample();
      chk("t4_dev2_blocked", 32'(d_o[2].a_valid), 32'd0);
      advance();
    end
    dev_rsp_en[1] = 1'b1;
    cycle();
    dev_rsp_en[1] = 1'b0;
    sample();
    chk("t4_dev2_a_valid", 32'(d_o[2].a_valid), 32'd1);
    chk("t4_dev2_a_ready", 32'(h_o.a_ready), 32'd1);
    advance();
    drain();

    // Simultaneous A and D handshakes at outstd=2.
    dev_rsp_en[4] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req(1'b1, 32'h4000_4000 + 32'(k * 4), Get, 8'(40 + k));
      cycle();
    end
    req(1'b1, 32'h4000_4008, Get, 8'd42);
    dev_rsp_en[4] = 1'b1;
    sample();
    chk("t5_both_hs", 32'(h_o.a_ready & h_o.d_valid), 32'd1);
    advance();
    chk("t5_outstd", 32'(outstd), 32'd2);
    drain();

    // Overlapping windows resolve to the lowest index; upper part of dev10 window.
    req(1'b1, 32'h4000_0100, Get, 8'd50);
    sample();
    chk("ovl_dev0", 32'(d_o[0].a_valid), 32'd1);
    chk("ovl_dev10", 32'(d_o[10].a_valid), 32'd0);
    advance();
    drain();
    req(1'b1, 32'h4000_B000, Get, 8'd51);
    sample();
    chk("dev10_hit", 32'(d_o[10].a_valid), 32'd1);
    advance();
    drain();

    // Error counter saturation.
    for (int k = 0; k < 260; k++) begin
      req(1'b1, 32'hDEAD_0000 + 32'(k), Get, 8'(k));
      cycle();
      h_i.a_valid = 1'b0;
      cycle();
    end
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int unsigned pick;
      logic [31:0] addr;
      pick = $urandom_range(0, 12);
      if (pick < 10) addr = 32'h4000_0000 + (32'(pick) << 12) + ($urandom & 32'hFFF);
      else if (pick == 10) addr = 32'h4000_A000 + 32'($urandom_range(0, 32'h5FFF));
      else addr = 32'h8000_0000 | $urandom;
      req($urandom_range(0, 3) != 0, addr, ($urandom_range(0, 1) != 0) ? Get : PutFullData,
          8'($urandom));
      h_i.a_size  = 2'($urandom);
      h_i.d_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NDEV; i++) begin
        dev_rdy[i]    = ($urandom_range(0, 4) != 0);
        dev_rsp_en[i] = ($urandom_range(0, 1) != 0);
        dev_data[i]   = $urandom;
      end
      cycle();
    end
    for (int i = 0; i < NDEV; i++) dev_rdy[i] = 1'b1;
    drain();

    // Reset while the error responder holds a response.
    h_i.d_ready = 1'b0;
    req(1'b1, 32'hDEAD_0000, Get, 8'd7);
    cycle();
    h_i.a_valid = 1'b0;
    sample();
    chk("t6_pre_d_valid", 32'(h_o.d_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_d_valid", 32'(h_o.d_valid), 32'd0);
    chk("t6_outstd", 32'(outstd), 32'd0);
    chk("t6_err_cnt", 32'(err_cnt), 32'd0);
    pend.delete();
    cur = 0;
    m_errcnt = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #2;
    h_i.d_ready = 1'b1;
    req(1'b1, 32'h4000_5000, Get, 8'd60);
    cycle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
